// File: rtl/saturation_pipe.sv
// Two-stage requantizer for convolution partial sums.
// S1 applies a rounding arithmetic right shift; S2 applies optional ReLU and clips
// to the signed output width. Valid/ready on both sides with full backpressure, plus
// a saturating count of clipped channel samples.
module saturation_pipe #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned I_SUM_BW = 21,
  parameter int unsigned O_SUM_BW = 16,
  parameter int unsigned SHIFT_BW = 4,
  parameter int unsigned CNT_BW   = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [SHIFT_BW-1:0]          i_shift,
  input  logic                         i_relu_en,
  input  logic                         i_cnt_clr,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [NUM_CH*I_SUM_BW-1:0]   s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_CH*O_SUM_BW-1:0]   m_data,
  output logic [CNT_BW-1:0]            o_sat_cnt
);

  // One extra bit so the rounding add can never overflow.
  localparam int unsigned RW   = I_SUM_BW + 1;
  localparam int unsigned IncW = $clog2(NUM_CH + 1);

  localparam logic signed [RW-1:0] OMax = RW'((1 << (O_SUM_BW - 1)) - 1);
  localparam logic signed [RW-1:0] OMin = ~OMax;

  logic                       v1_q;
  logic                       relu1_q;
  logic [NUM_CH*RW-1:0]       r1_q;
  logic [NUM_CH*RW-1:0]       r1_d;
  logic                       v2_q;
  logic [NUM_CH*O_SUM_BW-1:0] data2_q;
  logic [NUM_CH*O_SUM_BW-1:0] data2_d;
  logic [NUM_CH-1:0]          sat_evt;
  logic [CNT_BW-1:0]          cnt_q;
  logic [CNT_BW-1:0]          cnt_d;
  logic [IncW-1:0]            inc;
  logic [CNT_BW:0]            cnt_sum;
  logic                       s1_load;
  logic                       s2_load;
  logic                       s2_take;

  logic signed [RW-1:0]       xe;
  logic signed [RW-1:0]       rnd;
  logic signed [RW-1:0]       sum;
  logic signed [RW-1:0]       rr;

  assign s2_load = !v2_q || m_ready;
  assign s_ready = !v1_q || s2_load;
  assign s1_load = s_valid && s_ready;
  // A real beat moving S1 -> S2; only these update data and the counter.
  assign s2_take = v1_q && s2_load;

  assign m_valid   = v2_q;
  assign m_data    = data2_q;
  assign o_sat_cnt = cnt_q;

  // S1 datapath: sign-extend, add half an LSB of the shifted result, arithmetic shift.
  always_comb begin
    r1_d = '0;
    xe   = '0;
    rnd  = '0;
    sum  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      xe = {s_data[k*I_SUM_BW + I_SUM_BW - 1], s_data[k*I_SUM_BW +: I_SUM_BW]};
      if (i_shift == '0) begin
        sum = xe;
      end else begin
        rnd = RW'(1) << (i_shift - 1'b1);
        sum = xe + rnd;
        sum = sum >>> i_shift;
      end
      r1_d[k*RW +: RW] = sum;
    end
  end

  // S2 datapath: ReLU first (not a clip), then clip to the output range.
  always_comb begin
    data2_d = '0;
    sat_evt = '0;
    rr      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      rr = r1_q[k*RW +: RW];
      if (relu1_q && rr[RW-1]) begin
        data2_d[k*O_SUM_BW +: O_SUM_BW] = '0;
      end else if (rr > OMax) begin
        data2_d[k*O_SUM_BW +: O_SUM_BW] = {1'b0, {(O_SUM_BW-1){1'b1}}};
        sat_evt[k] = 1'b1;
      end else if (rr < OMin) begin
        data2_d[k*O_SUM_BW +: O_SUM_BW] = {1'b1, {(O_SUM_BW-1){1'b0}}};
        sat_evt[k] = 1'b1;
      end else begin
        data2_d[k*O_SUM_BW +: O_SUM_BW] = rr[O_SUM_BW-1:0];
      end
    end
  end

  // Saturating event counter; clear wins over a same-cycle increment.
  always_comb begin
    inc = '0;
    if (s2_take) begin
      for (int k = 0; k < NUM_CH; k++) begin
        inc = inc + IncW'(sat_evt[k]);
      end
    end
    cnt_sum = {1'b0, cnt_q} + (CNT_BW+1)'(inc);
    cnt_d   = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_sum[CNT_BW]) begin
      cnt_d = '1;
    end else begin
      cnt_d = cnt_sum[CNT_BW-1:0];
    end
  end

  // S1 registers: advance whenever the stage can accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q    <= 1'b0;
      relu1_q <= 1'b0;
      r1_q    <= '0;
    end else begin
      if (s_ready) begin
        v1_q <= s_valid;
      end
      if (s1_load) begin
        r1_q    <= r1_d;
        relu1_q <= i_relu_en;
      end
    end
  end

  // S2 registers: data held while stalled so m_data stays stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2_q    <= 1'b0;
      data2_q <= '0;
    end else begin
      if (s2_load) begin
        v2_q <= v1_q;
      end
      if (s2_take) begin
        data2_q <= data2_d;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_saturation_pipe.sv
// Scoreboard bench for saturation_pipe: a driver pushes model results on acceptance,
// a negedge monitor pops and compares on each output transfer and checks stall stability.
module tb_saturation_pipe;

  localparam int NUM_CH = 4;
  localparam int I_BW   = 21;
  localparam int O_BW   = 16;
  localparam int SH_BW  = 4;
  localparam int CNT_BW = 4;
  localparam int CntMax = (1 << CNT_BW) - 1;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [SH_BW-1:0]         i_shift = '0;
  logic                     i_relu_en = 1'b0;
  logic                     i_cnt_clr = 1'b0;
  logic                     s_valid = 1'b0;
  logic                     s_ready;
  logic [NUM_CH*I_BW-1:0]   s_data = '0;
  logic                     m_valid;
  logic                     m_ready = 1'b1;
  logic [NUM_CH*O_BW-1:0]   m_data;
  logic [CNT_BW-1:0]        o_sat_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  int exp_cnt = 0;
  int stall_cycles = 0;
  logic [NUM_CH*O_BW-1:0] exp_q[$];
  logic                   held_v = 1'b0;
  logic [NUM_CH*O_BW-1:0] held_d = '0;

  saturation_pipe #(
    .NUM_CH  (NUM_CH),
    .I_SUM_BW(I_BW),
    .O_SUM_BW(O_BW),
    .SHIFT_BW(SH_BW),
    .CNT_BW  (CNT_BW)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_shift  (i_shift),
    .i_relu_en(i_relu_en),
    .i_cnt_clr(i_cnt_clr),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .o_sat_cnt(o_sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [NUM_CH*I_BW-1:0] pack_in(input int a, input int b, input int c,
                                                     input int e);
    logic [NUM_CH*I_BW-1:0] t;
    t[0*I_BW +: I_BW] = I_BW'(a);
    t[1*I_BW +: I_BW] = I_BW'(b);
    t[2*I_BW +: I_BW] = I_BW'(c);
    t[3*I_BW +: I_BW] = I_BW'(e);
    return t;
  endfunction

  function automatic logic [NUM_CH*O_BW-1:0] pack_out(input int a, input int b, input int c,
                                                      input int e);
    logic [NUM_CH*O_BW-1:0] t;
    t[0*O_BW +: O_BW] = O_BW'(a);
    t[1*O_BW +: O_BW] = O_BW'(b);
    t[2*O_BW +: O_BW] = O_BW'(c);
    t[3*O_BW +: O_BW] = O_BW'(e);
    return t;
  endfunction

  // Reference: floor((x + d/2) / d) with d = 2^sh, then ReLU, then clip.
  task automatic model(input logic [NUM_CH*I_BW-1:0] d, input int sh, input bit relu,
                       output logic [NUM_CH*O_BW-1:0] o, output int nsat);
    logic signed [I_BW-1:0] xs;
    longint x, r, num, dv, hi, lo;
    hi   = (longint'(1) << (O_BW - 1)) - 1;
    lo   = -hi - 1;
    nsat = 0;
    o    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      xs = d[k*I_BW +: I_BW];
      x  = xs;
      if (sh == 0) begin
        r = x;
      end else begin
        dv  = longint'(1) << sh;
        num = x + dv / 2;
        r   = num / dv;
        if ((num % dv != 0) && (num < 0)) r = r - 1;
      end
      if (relu && r < 0) r = 0;
      else if (r > hi) begin r = hi; nsat++; end
      else if (r < lo) begin r = lo; nsat++; end
      o[k*O_BW +: O_BW] = r[O_BW-1:0];
    end
  endtask

  // Output monitor: scoreboard pop on transfer, stability check while stalled.
  initial begin
    logic [NUM_CH*O_BW-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          n_cmp++;
          if (m_valid !== 1'b1 || m_data !== held_d) begin
            n_bad++;
            $display("FAIL stall_hold: got v=%0b d=%h want v=1 d=%h", m_valid, m_data, held_d);
          end
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL extra_beat: got d=%h want no beat", m_data);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e) begin
              n_bad++;
              $display("FAIL out_data: got %h want %h", m_data, e);
            end
          end
          n_out++;
          held_v = 1'b0;
        end else if (m_valid === 1'b1) begin
          held_v = 1'b1;
          held_d = m_data;
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  // Present one beat and hold it until accepted; returns at posedge+1 after acceptance.
  task automatic send(input logic [NUM_CH*I_BW-1:0] d, input int sh, input bit relu);
    logic [NUM_CH*O_BW-1:0] o;
    int ns;
    int w;
    bit ok;
    s_data    = d;
    i_shift   = SH_BW'(sh);
    i_relu_en = relu;
    s_valid   = 1'b1;
    ok = 1'b0;
    for (w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      ok = (s_ready === 1'b1);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got s_ready=%b want 1", s_ready);
    end else begin
      stall_cycles += w - 1;
      model(d, sh, relu, o, ns);
      exp_q.push_back(o);
      exp_cnt = (exp_cnt + ns > CntMax) ? CntMax : exp_cnt + ns;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    s_valid = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_cnt(input string name, input int want);
    n_cmp++;
    if (o_sat_cnt !== CNT_BW'(want)) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, o_sat_cnt, want);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mvalid: got %b want 0", m_valid); end
    n_cmp++;
    if (m_data !== '0) begin n_bad++; $display("FAIL rst_mdata: got %h want 0", m_data); end
    check_cnt("rst_cnt", 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_sready: got %b want 1", s_ready); end
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    send(pack_in(40000, -40000, 100, -6), 0, 0);
    s_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early: got %b want 0", m_valid); end
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b1) begin n_bad++; $display("FAIL lat_valid: got %b want 1", m_valid); end
    n_cmp++;
    if (m_data !== pack_out(32767, -32768, 100, -6)) begin
      n_bad++;
      $display("FAIL single_data: got %h want %h", m_data, pack_out(32767, -32768, 100, -6));
    end
    drain();
    check_cnt("single_cnt", 2);
  endtask

  task automatic test_rounding();
    int xs[4] = '{100, -6, 1048575, -1048576};
    int sh[4] = '{2, 2, 15, 15};
    for (int i = 0; i < 4; i++) send(pack_in(xs[i], xs[i], xs[i], xs[i]), sh[i], 0);
    drain();
    check_cnt("round_cnt", 2);
  endtask

  task automatic test_relu();
    send(pack_in(-40000, -1, 32768, 5), 0, 1);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (m_data !== pack_out(0, 0, 32767, 5)) begin
      n_bad++;
      $display("FAIL relu_data: got %h want %h", m_data, pack_out(0, 0, 32767, 5));
    end
    drain();
    check_cnt("relu_cnt", 3);
  endtask

  task automatic test_backpressure();
    bit done;
    int out0;
    done = 1'b0;
    out0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(pack_in(100 * i, 100 * i + 1, -100 * i - 2, 100 * i + 3), i % 3, i[0]);
        end
        s_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          m_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
    join
    drain();
    n_cmp++;
    if (n_out - out0 != 8) begin
      n_bad++;
      $display("FAIL bp_count: got %0d want 8", n_out - out0);
    end
    check_cnt("bp_cnt", exp_cnt);
  endtask

  task automatic test_sready_drop();
    m_ready = 1'b0;
    stall_cycles = 0;
    send(pack_in(1, 2, 3, 4), 0, 0);
    send(pack_in(5, 6, 7, 8), 0, 0);
    n_cmp++;
    if (stall_cycles != 0) begin
      n_bad++;
      $display("FAIL fill_stall: got %0d want 0", stall_cycles);
    end
    s_data = pack_in(9, 10, 11, 12);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (s_ready !== 1'b0) begin n_bad++; $display("FAIL sready_drop: got %b want 0", s_ready); end
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    send(pack_in(9, 10, 11, 12), 0, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    int out0;
    out0 = n_out;
    m_ready = 1'b1;
    stall_cycles = 0;
    for (int i = 0; i < 6; i++) send(pack_in(i, -i, 2 * i, -3 * i), 1, 0);
    s_valid = 1'b0;
    n_cmp++;
    if (stall_cycles != 0) begin
      n_bad++;
      $display("FAIL b2b_stall: got %0d want 0", stall_cycles);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (n_out - out0 != 6) begin
      n_bad++;
      $display("FAIL b2b_out: got %0d want 6", n_out - out0);
    end
    drain();
  endtask

  task automatic test_cnt_sat();
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    i_cnt_clr = 1'b0;
    exp_cnt = 0;
    check_cnt("clr_idle", 0);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(pack_in(40000, -40000, 50000, -50000), 0, 0);
    send(pack_in(40000, -40000, 1, 2), 0, 0);
    drain();
    check_cnt("cnt_14", 14);
    send(pack_in(40000, -40000, 50000, -50000), 0, 0);
    drain();
    check_cnt("cnt_15", 15);
    send(pack_in(40000, -40000, 50000, -50000), 0, 0);
    drain();
    check_cnt("cnt_hold", 15);
  endtask

  task automatic test_cnt_clr();
    send(pack_in(40000, -40000, 50000, -50000), 0, 0);
    s_valid   = 1'b0;
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    i_cnt_clr = 1'b0;
    exp_cnt = 0;
    check_cnt("clr_vs_inc", 0);
    drain();
    check_cnt("clr_after", 0);
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    send(pack_in(40000, -40000, 50000, -50000), 0, 0);
    send(pack_in(11, 12, 13, 14), 0, 0);
    s_valid = 1'b0;
    check_cnt("mid_pre", 4);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_mvalid: got %b want 0", m_valid); end
    n_cmp++;
    if (m_data !== '0) begin n_bad++; $display("FAIL mid_mdata: got %h want 0", m_data); end
    check_cnt("mid_cnt", 0);
    exp_q.delete();
    exp_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale: got %b want 0", m_valid); end
    @(posedge clk);
    #1;
    send(pack_in(7, -8, 9, -10), 3, 0);
    s_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_lat0: got %b want 0", m_valid); end
    @(negedge clk);
    n_cmp++;
    if (m_valid !== 1'b1) begin n_bad++; $display("FAIL mid_lat1: got %b want 1", m_valid); end
    drain();
    check_cnt("mid_end", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rounding();
    test_relu();
    test_backpressure();
    test_sready_drop();
    test_back_to_back();
    test_cnt_sat();
    test_cnt_clr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/saturation_pipe.md
Name: saturation_pipe

Overview:
- Multi-channel, pipelined requantizer for convolution partial sums. It sits between the accumulator array and the output write-back/AXI stream path.
- Per channel, it applies a rounding arithmetic right shift, then an optional ReLU, then clips to the signed output width.
- It uses valid/ready handshakes with full backpressure.
- It keeps a saturating counter of clipped samples for debug and calibration.

Parameters:
- NUM_CH, 4, number of parallel channels per beat.
- I_SUM_BW, 21, signed input partial-sum width per channel.
- O_SUM_BW, 16, signed output width per channel; must be less than I_SUM_BW.
- SHIFT_BW, 4, width of the shift-amount control; the shift range is 0..2^SHIFT_BW-1 and must be less than I_SUM_BW.
- CNT_BW, 32, width of the saturation event counter.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_shift  in  SHIFT_BW  rounding right-shift amount; sampled with each accepted input beat.
- i_relu_en  in  1  ReLU enable; sampled with each accepted input beat.
- i_cnt_clr  in  1  synchronous clear of o_sat_cnt.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready.
- s_data  in  NUM_CH*I_SUM_BW  packed signed sums; channel k occupies bits [k*I_SUM_BW +: I_SUM_BW].
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  NUM_CH*O_SUM_BW  packed signed results; channel k occupies bits [k*O_SUM_BW +: O_SUM_BW].
- o_sat_cnt  out  CNT_BW  count of clipped channel samples.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - Both stage valid flags clear.
  - m_valid=0, m_data=0, o_sat_cnt=0.
  - s_ready=1 once reset deasserts.
  - Reset mid-operation discards all in-flight beats and produces no partial output.
- Pipeline: two register stages, S1 (round/shift) and S2 (clip/output). m_data and m_valid are driven directly from the S2 registers.
- Transfers happen only when valid and ready are both high on a rising edge.
- Stall and flow rules:
  - S2 loads when it is empty or m_ready=1.
  - S1 advances into S2 under the same condition.
  - s_ready = !v1 || (S2 empty or m_ready).
  - Latency is 2 cycles from acceptance to m_valid with no backpressure.
  - Throughput is 1 beat/cycle with no bubbles under continuous valid/ready.
  - m_data holds stable while m_valid=1 && m_ready=0.
  - No beat is dropped or duplicated.
- S1 arithmetic, per channel, on input x:
  - sh=0: r = x, sign-extended to I_SUM_BW+1 bits.
  - sh>0: r = (x + 2^(sh-1)) >>> sh, computed in I_SUM_BW+1 bits so that the rounding add cannot overflow. This is round-half-up, i.e. toward +inf on ties.
  - i_relu_en is captured alongside the S1 data.
- S2 arithmetic, per channel, on r:
  - If relu_en and r<0, the output is 0. This is not a saturation event.
  - Else if r > 2^(O_SUM_BW-1)-1, the output is 0x7FFF (O_SUM_BW=16); saturation event.
  - Else if r < -2^(O_SUM_BW-1), the output is 0x8000; saturation event.
  - Otherwise the output is r truncated to O_SUM_BW bits, which is exact in range.
  - Values exactly at ±limit pass through and are not counted.
- Saturation counter:
  - On each S2 load, o_sat_cnt += popcount(channel saturation events), range 0..NUM_CH.
  - The counter saturates at 2^CNT_BW-1 and never wraps.
  - i_cnt_clr has priority over an increment in the same cycle: the result is 0, and that cycle's events are lost.
  - The counter is updated only on an S2 load, never on stalled cycles.
- Control changes: i_shift and i_relu_en may change on any cycle. Each beat uses the values present at its own acceptance.

Test Plan:
- Reset, single beat (no backpressure): s_data channels = {40000, -40000, 100, -6}, shift=0, relu=0 -> m_valid 2 cycles after acceptance; m_data = {32767, -32768, 100, -6}; o_sat_cnt=2.
- Rounding: x = {100, -6, 1048575, -1048576} with shift=2, 2, 15, 15 (one beat per shift value) -> outputs 25, -1, 32, -32; no saturation counts.
- ReLU: x = {-40000, -1, 32768, 5}, relu=1, shift=0 -> m_data = {0, 0, 32767, 5}; o_sat_cnt increments by 1 only.
- Backpressure:
  - Stream 8 beats with incrementing values and toggle m_ready in a pseudo-random pattern -> output order and values exact, m_data stable during stalls, no loss or duplication.
  - With m_ready held 0, s_ready drops after 2 beats accepted.
- Counter edges:
  - Preload via many saturating beats to 2^CNT_BW-2 (use CNT_BW=4 in a bench parameter), then a beat with 4 saturations -> 15, held.
  - i_cnt_clr asserted concurrently with a saturating S2 load -> 0.
- Reset mid-stream: assert reset_n=0 asynchronously while both stages are valid -> m_valid=0 immediately, o_sat_cnt=0; after release, the first new beat emerges with correct latency and no stale data.
